// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key-schedule datapaths.
//   - SBOX / sbox()  : forward AES S-box lookup
//   - rcon()         : round constant, indexed 1..10 (0 outside that range)
//   - rke_state_t    : inverse key schedule controller states
//   - NK_/NR_ consts : the legal key-length / round-count pairs
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NK_AES128 = 4;
  localparam int NR_AES128 = 10;
  localparam int NK_AES256 = 8;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GEN  = 2'd2,
    DONE = 2'd3
  } rke_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/sub_word.sv
// -----------------------------------------------------------------------------
// sub_word
// AES SubWord: four independent S-box lookups on one 32-bit word.
// Purely combinational; shared by the forward and inverse key paths.
// Ports:
//   i_word [31:0]  input word (MSB byte = byte 0)
//   o_word [31:0]  byte-wise S-box substitution of i_word
// -----------------------------------------------------------------------------
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign o_word[gi*8 +: 8] = sbox(i_word[gi*8 +: 8]);
  end

endmodule

// File: rtl/reverse_key_expansion.sv
// -----------------------------------------------------------------------------
// reverse_key_expansion
// Sequential AES inverse key schedule. Loaded with the last NK words of the
// expanded key, it walks the schedule backwards one word per clock and
// streams round keys NR..0 over a valid/ready handshake.
// Parameters:
//   NK  key length in words (4 = AES-128, 8 = AES-256)
//   NR  rounds (10 for NK=4, 14 for NK=8)
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      load i_last_key (only honoured in IDLE)
//   i_last_key   w[4(NR+1)-NK] .. w[4(NR+1)-1], lowest-indexed word in MSBs
//   i_ready      consumer accepts o_round_key
//   o_round_key  current round key, lowest-indexed word in MSBs
//   o_round_idx  round number of o_round_key
//   o_valid      o_round_key / o_round_idx valid
//   o_busy       operation in progress (any state other than IDLE)
//   o_done       one-cycle pulse after round 0 is accepted
// -----------------------------------------------------------------------------
module reverse_key_expansion
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [NK*32-1:0]  i_last_key,
  input  logic              i_ready,
  output logic [127:0]      o_round_key,
  output logic [3:0]        o_round_idx,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int         NW_TOTAL = 4 * (NR + 1);
  localparam int         B_LOAD   = NW_TOTAL - NK;
  localparam int         LOG_NK   = (NK == 8) ? 3 : 2;
  localparam logic [6:0] NK_MASK  = 7'(NK - 1);

  rke_state_t r_state;
  rke_state_t w_state_next;

  // Window word k lives at w_win[k*32 +: 32] and holds w[b+k].
  logic [NK*32-1:0] w_win;
  logic [5:0]       r_b;
  logic [3:0]       r_idx;
  logic [1:0]       r_step;
  logic             r_lower;

  logic [6:0]  w_i;
  logic [6:0]  w_imod;
  logic [3:0]  w_rcon_idx;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_f;
  logic [31:0] w_new;
  logic        w_load;
  logic        w_shift;
  logic        w_half_split;

  assign w_load  = (r_state == IDLE) && i_start;
  assign w_shift = (r_state == GEN);

  // For AES-256 the final 8-word window already contains rounds 1 and 0,
  // so once b reaches 0 the lower half is presented without further steps.
  assign w_half_split = (NK == 8) && (r_b == 6'd0);

  // ---------------------------------------------------------------------------
  // Backward step: w[b-1] = w[b-1+NK] ^ f(w[b-2+NK]), i = b-1+NK
  // ---------------------------------------------------------------------------
  assign w_i        = 7'(r_b) + NK_MASK;
  assign w_imod     = w_i & NK_MASK;
  assign w_rcon_idx = 4'(w_i >> LOG_NK);
  assign w_sub_in   = w_win[(NK-2)*32 +: 32];

  sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // SubWord is byte-wise, so SubWord(RotWord(x)) == RotWord(SubWord(x)):
  // rotating after the lookup keeps a single S-box bank on the f() input.
  always_comb begin
    w_f = w_sub_in;
    if (w_imod == 7'd0) begin
      w_f = {w_sub_out[23:0], w_sub_out[31:24]} ^ {rcon(w_rcon_idx), 24'h0};
    end else if ((NK == 8) && (w_imod == 7'd4)) begin
      w_f = w_sub_out;
    end
  end

  assign w_new = w_win[(NK-1)*32 +: 32] ^ w_f;

  // ---------------------------------------------------------------------------
  // Window registers: parallel load on start, shift up by one word per GEN
  // cycle with the regenerated word entering at the bottom.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NK; gi++) begin : g_win
    logic [31:0] r_word;
    logic [31:0] w_shift_in;

    if (gi == 0) begin : g_head
      assign w_shift_in = w_new;
    end else begin : g_tail
      assign w_shift_in = w_win[(gi-1)*32 +: 32];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_word <= '0;
      end else if (w_load) begin
        r_word <= i_last_key[(NK-1-gi)*32 +: 32];
      end else if (w_shift) begin
        r_word <= w_shift_in;
      end
    end

    assign w_win[gi*32 +: 32] = r_word;
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = EMIT;
        end
      end
      EMIT: begin
        if (i_ready) begin
          if (r_idx == 4'd0) begin
            w_state_next = DONE;
          end else if (w_half_split) begin
            w_state_next = EMIT;
          end else begin
            w_state_next = GEN;
          end
        end
      end
      GEN: begin
        if (r_step == 2'd3) begin
          w_state_next = EMIT;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_b     <= '0;
      r_idx   <= '0;
      r_step  <= '0;
      r_lower <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_b     <= 6'(B_LOAD);
            r_idx   <= 4'(NR);
            r_step  <= '0;
            r_lower <= 1'b0;
          end
        end
        EMIT: begin
          if (i_ready && (r_idx != 4'd0)) begin
            if (w_half_split) begin
              r_lower <= 1'b1;
              r_idx   <= 4'd0;
            end else begin
              r_idx <= r_idx - 4'd1;
            end
          end
        end
        GEN: begin
          // Counter wraps 3 -> 0, so it is already cleared for the next GEN.
          r_b    <= r_b - 6'd1;
          r_step <= r_step + 2'd1;
        end
        DONE: begin
          r_lower <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_round_key = r_lower
                     ? {w_win[0 +: 32], w_win[32 +: 32], w_win[64 +: 32], w_win[96 +: 32]}
                     : {w_win[(NK-4)*32 +: 32], w_win[(NK-3)*32 +: 32],
                        w_win[(NK-2)*32 +: 32], w_win[(NK-1)*32 +: 32]};
  assign o_round_idx = r_idx;
  assign o_valid     = (r_state == EMIT);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);

endmodule
